// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master data-memory arbiter: bus widths and FSM states.
package mem_arbiter_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;

  typedef logic [MEM_DATA_W-1:0] MemBus;
  typedef logic [MEM_ADDR_W-1:0] MemAddrBus;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT0,
    ARB_GNT1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_fsm.sv
// Round-robin grant FSM with a last-granted pointer; the optional burst counter
// is compiled in when ARB_BURST_LIMIT_EN is defined.
module mem_arbiter_fsm
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
    $error("mem_arbiter_fsm: BURST_MAX must be in 1..255");
  end

  arb_state_e state;
  arb_state_e next_state;
  logic       last;
  logic       burst_hit;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BURST_MAX - 1);

  logic [CNT_W-1:0] cnt;

  assign burst_hit = (cnt == CNT_TOP);

  // Counts cycles spent in the current grant; restarts whenever ownership changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (next_state != state || next_state == ARB_IDLE) begin
      cnt <= '0;
    end else if (cnt != CNT_TOP) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state != state && next_state == ARB_GNT0) last <= 1'b0;
      if (next_state != state && next_state == ARB_GNT1) last <= 1'b1;
    end
  end

  // An owner dropping its request hands straight over, with no IDLE bubble.
  always_comb begin
    next_state = state;
    unique case (state)
      ARB_IDLE: begin
        if (req0 && req1)  next_state = last ? ARB_GNT0 : ARB_GNT1;
        else if (req0)     next_state = ARB_GNT0;
        else if (req1)     next_state = ARB_GNT1;
      end
      ARB_GNT0: begin
        if (req0) begin
          if (req1 && burst_hit) next_state = ARB_GNT1;
        end else begin
          next_state = req1 ? ARB_GNT1 : ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (req1) begin
          if (req0 && burst_hit) next_state = ARB_GNT0;
        end else begin
          next_state = req0 ? ARB_GNT0 : ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  assign gnt0 = (state == ARB_GNT0);
  assign gnt1 = (state == ARB_GNT1);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single bus master port between m0 (core LSU) and m1 (DMA/debug).
// Define ARB_BURST_LIMIT_EN to force hand-over after BURST_MAX cycles under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      m0_req,
  input  MemAddrBus m0_waddr,
  input  MemAddrBus m0_raddr,
  input  MemBus     m0_wdata,
  input  logic [3:0] m0_we,
  output logic      m0_gnt,
  output MemBus     m0_rdata,
  input  logic      m1_req,
  input  MemAddrBus m1_waddr,
  input  MemAddrBus m1_raddr,
  input  MemBus     m1_wdata,
  input  logic [3:0] m1_we,
  output logic      m1_gnt,
  output MemBus     m1_rdata,
  output MemAddrBus s_waddr,
  output MemAddrBus s_raddr,
  output MemBus     s_wdata,
  output logic [3:0] s_we,
  input  MemBus     s_rdata
);

  mem_arbiter_fsm #(
    .BURST_MAX(BURST_MAX)
  ) u_fsm (
    .clk (clk),
    .rst (rst),
    .req0(m0_req),
    .req1(m1_req),
    .gnt0(m0_gnt),
    .gnt1(m1_gnt)
  );

  // Write enables are masked by req so a grant lingering after req drops cannot write.
  always_comb begin
    s_waddr = '0;
    s_raddr = '0;
    s_wdata = '0;
    s_we    = 4'b0;
    if (m0_gnt) begin
      s_waddr = m0_waddr;
      s_raddr = m0_raddr;
      s_wdata = m0_wdata;
      s_we    = m0_req ? m0_we : 4'b0;
    end else if (m1_gnt) begin
      s_waddr = m1_waddr;
      s_raddr = m1_raddr;
      s_wdata = m1_wdata;
      s_we    = m1_req ? m1_we : 4'b0;
    end
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word RAM behind the slave port.
// Burst-limit expectations follow ARB_BURST_LIMIT_EN, with BURST_MAX fixed at 4.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int BMAX = 4;

  logic       clk;
  logic       rst;
  logic       m0_req, m1_req;
  MemAddrBus  m0_waddr, m0_raddr, m1_waddr, m1_raddr;
  MemBus      m0_wdata, m1_wdata;
  logic [3:0] m0_we, m1_we;
  logic       m0_gnt, m1_gnt;
  MemBus      m0_rdata, m1_rdata;
  MemAddrBus  s_waddr, s_raddr;
  MemBus      s_wdata;
  logic [3:0] s_we;
  MemBus      s_rdata;

  MemBus ram [0:31];

  int checks = 0;
  int errors = 0;
  bit burst_en;

  mem_arbiter #(.BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_waddr(m0_waddr), .m0_raddr(m0_raddr),
    .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_waddr(m1_waddr), .m1_raddr(m1_raddr),
    .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .s_waddr(s_waddr), .s_raddr(s_raddr), .s_wdata(s_wdata), .s_we(s_we),
    .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-enabled word RAM standing in for the bus and its slaves.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (s_we[b]) ram[s_waddr[6:2]][8*b +: 8] <= s_wdata[8*b +: 8];
  end
  assign s_rdata = ram[s_raddr[6:2]];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
`ifdef ARB_BURST_LIMIT_EN
    burst_en = 1'b1;
`else
    burst_en = 1'b0;
`endif
    for (int i = 0; i < 32; i++) ram[i] = '0;
    rst = 1'b0;
    m0_req = 0; m1_req = 0;
    m0_waddr = '0; m0_raddr = '0; m0_wdata = '0; m0_we = '0;
    m1_waddr = '0; m1_raddr = '0; m1_wdata = '0; m1_we = '0;
    #1 rst = 1'b1;

    // Reset state.
    cycle();
    cycle();
    checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("rst_s_we", 32'(s_we), 32'd0);
    checkOutput("rst_s_waddr", s_waddr, 32'd0);
    rst = 1'b0;

    // Single master m1 write then read back.
    m1_req = 1; m1_waddr = 32'h10; m1_raddr = 32'h10; m1_we = 4'hF; m1_wdata = 32'hDEADBEEF;
    #1;
    checkOutput("m1_gnt_latency", 32'(m1_gnt), 32'd0);
    cycle();
    checkOutput("m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("m1_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("m1_s_waddr", s_waddr, 32'h10);
    checkOutput("m1_s_raddr", s_raddr, 32'h10);
    checkOutput("m1_s_wdata", s_wdata, 32'hDEADBEEF);
    checkOutput("m1_s_we", 32'(s_we), 32'hF);
    cycle();
    m1_we = 4'h0;
    #1;
    checkOutput("m1_rdata", m1_rdata, 32'hDEADBEEF);
    checkOutput("m0_rdata_bcast", m0_rdata, 32'hDEADBEEF);
    m1_req = 0;
    cycle();
    checkOutput("m1_release", 32'(m1_gnt), 32'd0);
    checkOutput("idle_s_waddr", s_waddr, 32'd0);

    // Reset pulse, then tie from reset goes to m0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m0_req = 1; m1_req = 1; m0_waddr = 32'h20; m1_waddr = 32'h30;
    cycle();
    checkOutput("tie_m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("tie_m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("tie_s_waddr", s_waddr, 32'h20);
    m0_req = 0;
    cycle();
    checkOutput("handover_m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("handover_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("handover_s_waddr", s_waddr, 32'h30);
    m1_req = 0;
    cycle();
    checkOutput("both_drop_idle", 32'({m0_gnt, m1_gnt}), 32'd0);
    m0_req = 1; m1_req = 1;
    cycle();
    checkOutput("retie_m0_gnt", 32'(m0_gnt), 32'd1);

    // Contention with both requests held high; cycle 0 is the entry cycle above.
    for (int i = 1; i < 12; i++) begin
      logic exp0;
      cycle();
      exp0 = burst_en ? (((i / BMAX) % 2) == 0) : 1'b1;
      checkOutput($sformatf("burst_m0_c%0d", i), 32'(m0_gnt), 32'(exp0));
      checkOutput($sformatf("burst_m1_c%0d", i), 32'(m1_gnt), 32'(!exp0));
    end

    // Mid-cycle reset with a pending m0 write: drop everything immediately.
    m1_req = 0;
    cycle();
    checkOutput("pre_rst_m0_gnt", 32'(m0_gnt), 32'd1);
    m0_waddr = 32'h44; m0_wdata = 32'hCAFEF00D; m0_we = 4'hF;
    rst = 1'b1;
    #1;
    checkOutput("midrst_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("midrst_s_we", 32'(s_we), 32'd0);
    checkOutput("midrst_s_wdata", s_wdata, 32'd0);
    m0_we = 4'h0;
    cycle();
    rst = 1'b0;
    #1;
    checkOutput("rel_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("midrst_ram", ram[17], 32'd0);
    cycle();
    checkOutput("post_rst_m0_gnt", 32'(m0_gnt), 32'd1);

    // Granted m0 drops req in its last cycle while we is high: no write.
    m0_req = 0; m0_waddr = 32'h40; m0_wdata = 32'h12345678; m0_we = 4'hF;
    #1;
    checkOutput("mask_m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("mask_s_we", 32'(s_we), 32'd0);
    cycle();
    checkOutput("mask_idle", 32'(m0_gnt), 32'd0);
    checkOutput("mask_ram", ram[16], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
